nasti_stream_mover: RTL and testbench
=====================================

# nasti_stream_mover

Memory-to-stream data mover: takes a read command (address, length in words) on a NASTI-Stream command channel, issues NASTI read bursts of up to MAX_BURST_LENGTH beats, and forwards the returned data as a NASTI-Stream packet terminated by `t_last`. It is the read-direction counterpart of the stream-to-NASTI write mover. It sits between the memory-side NASTI crossbar and stream consumers such as the Ethernet TX and SD paths, and is driven by the same software command format.

## Interface
- ADDR_WIDTH, 64, NASTI address width
- DATA_WIDTH, 64, data width of memory and stream; DATA_BYTE_CNT = DATA_WIDTH/8, ADDR_SHIFT = log2(DATA_BYTE_CNT), LEN_WIDTH = ADDR_SHIFT+16
- MAX_BURST_LENGTH, 8, maximum beats per AR burst; must be a power of two, at most 256
- aclk  in  1  clock; all logic on the rising edge
- aresetn  in  1  asynchronous active-low reset
- src  nasti_channel.master  —  memory read port. AW, W and B are tied off: valids 0, b_ready 0.
- dest  nasti_stream_channel.master  —  output packet
- command  nasti_stream_channel.slave  —  command word, packed MSB to LSB:
  - addr[ADDR_WIDTH-1:ADDR_SHIFT]
  - length[LEN_WIDTH-1:ADDR_SHIFT], in words
  - reserved[7:0], ignored
- start_valid  in  1  arm request from control logic
- start_ready  out  1  high in IDLE
- err  out  1  sticky: some r_resp != 0 during the current command; cleared when a command is accepted

## Operation
- States: IDLE, COMMAND, ADDRESS, READ, DRAIN.
  - IDLE: `start_ready`=1. `start_valid` moves to COMMAND.
  - COMMAND: `command.t_ready`=1. `command.t_valid` latches addr and remaining length, and clears err.
    - length==0: go to IDLE. No AR is issued and no stream beat is produced.
    - otherwise: go to ADDRESS.
  - ADDRESS: `ar_valid`=1.
    - ar_addr = {addr, ADDR_SHIFT zeros}
    - ar_len = min(remaining, MAX_BURST_LENGTH) − 1
    - On ar fire: addr += beats, remaining −= beats, burst beat counter loaded, go to READ.
  - READ: accept R beats into the output register.
    - On the beat with r_last, go to ADDRESS if remaining != 0, else DRAIN.
  - DRAIN: wait until the output register is empty (`t_valid`=0 or it fires this cycle), then go to IDLE.
- Fixed AR fields:
  - ar_id=0, ar_size=ADDR_SHIFT, ar_burst=INCR(2'b01)
  - ar_cache, ar_prot, ar_lock, ar_qos, ar_region, ar_user = 0
- Only one burst is outstanding at a time. Bursts are not split at 4 KiB; software keeps commands 4 KiB-safe.
- Output register:
  - single entry, driving dest.t_data/t_valid/t_last
  - t_keep and t_strb are all ones
  - t_last=1 only on the final beat of the command, i.e. r_last with remaining==0
- `r_ready` = (state==READ) && (!dest.t_valid || dest.t_ready). A full register with a stalled sink backpressures R.
- r_resp != 0: data is still forwarded and err is set. The burst count is unaffected.
- Arithmetic:
  - addr wraps modulo 2^(ADDR_WIDTH−ADDR_SHIFT)
  - remaining never underflows, because beats ≤ remaining
- r_last must coincide with the counted final beat. A mismatch is an assertion error; the beat counter governs the state transition.

## Timing
- Reset values:
  - state IDLE
  - ar_valid 0, r_ready 0
  - dest.t_valid 0, dest.t_last 0
  - command.t_ready 0, start_ready 1
  - err 0
- Latencies:
  - command accepted in cycle N → ar_valid in cycle N+1
  - R beat accepted in cycle M → dest.t_valid in cycle M+1
  - r_last accepted in cycle M with more to read → next ar_valid in cycle M+1
- Throughput: one beat per cycle while the sink is ready.
- Once asserted, dest.t_valid and t_data hold until t_ready is seen.
- Reset mid-transfer: everything is aborted at once and state returns to IDLE. In-flight NASTI responses are the interconnect's concern.

## Test plan
- Command addr=0x1000, len=8, sink always ready:
  - one AR with ar_len=7
  - 8 stream beats, data matching memory
  - t_last on the 8th beat only
  - state back in IDLE
- len=20, MAX=8:
  - three ARs at 0x1000/len7, 0x1040/len7, 0x1080/len3
  - 20 beats, a single t_last
- len=0: command accepted, no AR, no stream beat, start_ready high again 1 cycle later.
- Sink toggles t_ready every other cycle with len=8:
  - r_ready drops whenever the register is full and unaccepted
  - no data lost or duplicated, order preserved
- Memory returns r_resp=2'b10 on beat 3 of len=4: all 4 beats forwarded, err=1 until the next command is accepted.
- aresetn asserted during READ of beat 5/8: all outputs take their reset values asynchronously. The next command after release runs cleanly.

Source files
------------

// File: rtl/nasti_stream_mover.sv
// nasti_stream_mover
//   Memory-to-stream data mover. A software command (word address, length in
//   words) arrives on the command stream after the control logic arms the
//   block through start_valid/start_ready. The mover issues NASTI INCR read
//   bursts of up to MAX_BURST_LENGTH beats, one outstanding at a time, and
//   forwards every returned beat through a single-entry output register as a
//   stream packet whose last beat carries t_last.
//
// Ports
//   aclk, aresetn      clock (rising edge) / asynchronous active-low reset
//   o_src_aw_* / w_*   write address/data channels, tied off (valid 0)
//   o_src_b_ready      write response ready, tied off (0)
//   o_src_ar_*         read address channel (master)
//   i_src_r_*          read data channel (master side, o_src_r_ready)
//   o_dest_t_*         output packet stream (master)
//   i_cmd_t_* / o_cmd_t_ready
//                      command stream (slave): {addr words, length words, rsvd[7:0]}
//   i_start_valid      arm request; o_start_ready high while idle
//   o_err              sticky error: any non-OKAY r_resp in the current command

module nasti_stream_mover #(
  parameter  int ADDR_WIDTH       = 64,
  parameter  int DATA_WIDTH       = 64,
  parameter  int MAX_BURST_LENGTH = 8,
  parameter  int ID_WIDTH         = 1,
  parameter  int USER_WIDTH       = 1,
  localparam int DATA_BYTE_CNT    = DATA_WIDTH / 8,
  localparam int ADDR_SHIFT       = $clog2(DATA_BYTE_CNT),
  localparam int LEN_WIDTH        = ADDR_SHIFT + 16,
  localparam int CMD_WIDTH        = ADDR_WIDTH + LEN_WIDTH - 2 * ADDR_SHIFT + 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  // AW (unused)
  output logic                     o_src_aw_valid,
  input  logic                     i_src_aw_ready,
  output logic [ID_WIDTH-1:0]      o_src_aw_id,
  output logic [ADDR_WIDTH-1:0]    o_src_aw_addr,
  output logic [7:0]               o_src_aw_len,
  output logic [2:0]               o_src_aw_size,
  output logic [1:0]               o_src_aw_burst,
  output logic                     o_src_aw_lock,
  output logic [3:0]               o_src_aw_cache,
  output logic [2:0]               o_src_aw_prot,
  output logic [3:0]               o_src_aw_qos,
  output logic [3:0]               o_src_aw_region,
  output logic [USER_WIDTH-1:0]    o_src_aw_user,
  // W (unused)
  output logic                     o_src_w_valid,
  input  logic                     i_src_w_ready,
  output logic [DATA_WIDTH-1:0]    o_src_w_data,
  output logic [DATA_BYTE_CNT-1:0] o_src_w_strb,
  output logic                     o_src_w_last,
  output logic [USER_WIDTH-1:0]    o_src_w_user,
  // B (unused)
  input  logic                     i_src_b_valid,
  output logic                     o_src_b_ready,
  input  logic [ID_WIDTH-1:0]      i_src_b_id,
  input  logic [1:0]               i_src_b_resp,
  input  logic [USER_WIDTH-1:0]    i_src_b_user,
  // AR
  output logic                     o_src_ar_valid,
  input  logic                     i_src_ar_ready,
  output logic [ID_WIDTH-1:0]      o_src_ar_id,
  output logic [ADDR_WIDTH-1:0]    o_src_ar_addr,
  output logic [7:0]               o_src_ar_len,
  output logic [2:0]               o_src_ar_size,
  output logic [1:0]               o_src_ar_burst,
  output logic                     o_src_ar_lock,
  output logic [3:0]               o_src_ar_cache,
  output logic [2:0]               o_src_ar_prot,
  output logic [3:0]               o_src_ar_qos,
  output logic [3:0]               o_src_ar_region,
  output logic [USER_WIDTH-1:0]    o_src_ar_user,
  // R
  input  logic                     i_src_r_valid,
  output logic                     o_src_r_ready,
  input  logic [ID_WIDTH-1:0]      i_src_r_id,
  input  logic [DATA_WIDTH-1:0]    i_src_r_data,
  input  logic [1:0]               i_src_r_resp,
  input  logic                     i_src_r_last,
  input  logic [USER_WIDTH-1:0]    i_src_r_user,
  // output stream
  output logic                     o_dest_t_valid,
  input  logic                     i_dest_t_ready,
  output logic [DATA_WIDTH-1:0]    o_dest_t_data,
  output logic [DATA_BYTE_CNT-1:0] o_dest_t_keep,
  output logic [DATA_BYTE_CNT-1:0] o_dest_t_strb,
  output logic                     o_dest_t_last,
  // command stream
  input  logic                     i_cmd_t_valid,
  output logic                     o_cmd_t_ready,
  input  logic [CMD_WIDTH-1:0]     i_cmd_t_data,
  // control
  input  logic                     i_start_valid,
  output logic                     o_start_ready,
  output logic                     o_err
);

  localparam int AW_W   = ADDR_WIDTH - ADDR_SHIFT;    // word-address width
  localparam int BEAT_W = $clog2(MAX_BURST_LENGTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_COMMAND, S_ADDRESS, S_READ, S_DRAIN
  } state_t;

  state_t                  r_state;
  logic [AW_W-1:0]         r_addr;
  logic [15:0]             r_remain;
  logic [BEAT_W-1:0]       r_beats;     // beats still owed by the open burst
  logic                    r_ar_valid;
  logic                    r_cmd_ready;
  logic                    r_start_ready;
  logic                    r_err;
  logic                    r_t_valid;
  logic                    r_t_last;
  logic [DATA_WIDTH-1:0]   r_t_data;

  logic [AW_W-1:0]         w_cmd_addr;
  logic [15:0]             w_cmd_len;
  logic [15:0]             w_burst;
  logic                    w_r_ready;
  logic                    w_r_fire;
  logic                    w_beat_final;

  assign w_cmd_addr = i_cmd_t_data[CMD_WIDTH-1 -: AW_W];
  assign w_cmd_len  = i_cmd_t_data[8 +: 16];

  // Beats in the next burst: min(remaining, MAX_BURST_LENGTH)
  assign w_burst = (r_remain > 16'(MAX_BURST_LENGTH)) ? 16'(MAX_BURST_LENGTH) : r_remain;

  // The register may take a beat when empty or being drained this cycle.
  assign w_r_ready    = (r_state == S_READ) && (!r_t_valid || i_dest_t_ready);
  assign w_r_fire     = w_r_ready && i_src_r_valid;
  assign w_beat_final = (r_beats == BEAT_W'(1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_remain      <= '0;
      r_beats       <= '0;
      r_ar_valid    <= 1'b0;
      r_cmd_ready   <= 1'b0;
      r_start_ready <= 1'b1;
      r_err         <= 1'b0;
      r_t_valid     <= 1'b0;
      r_t_last      <= 1'b0;
      r_t_data      <= '0;
    end else begin
      // Sink took the held beat; an R beat accepted below reloads it.
      if (r_t_valid && i_dest_t_ready) begin
        r_t_valid <= 1'b0;
        r_t_last  <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (i_start_valid) begin
            r_start_ready <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_state       <= S_COMMAND;
          end
        end
        S_COMMAND: begin
          if (i_cmd_t_valid) begin
            r_cmd_ready <= 1'b0;
            r_addr      <= w_cmd_addr;
            r_remain    <= w_cmd_len;
            r_err       <= 1'b0;
            if (w_cmd_len == 16'd0) begin
              r_start_ready <= 1'b1;
              r_state       <= S_IDLE;
            end else begin
              r_ar_valid <= 1'b1;
              r_state    <= S_ADDRESS;
            end
          end
        end
        S_ADDRESS: begin
          if (i_src_ar_ready) begin
            r_ar_valid <= 1'b0;
            r_addr     <= r_addr + AW_W'(w_burst);
            r_remain   <= r_remain - w_burst;
            r_beats    <= BEAT_W'(w_burst);
            r_state    <= S_READ;
          end
        end
        S_READ: begin
          if (w_r_fire) begin
            r_t_valid <= 1'b1;
            r_t_data  <= i_src_r_data;
            // r_remain already excludes the open burst, so zero here means
            // this burst is the command's last one.
            r_t_last  <= w_beat_final && (r_remain == 16'd0);
            r_beats   <= r_beats - BEAT_W'(1);
            if (i_src_r_resp != 2'b00) r_err <= 1'b1;
            // The counter, not r_last, decides when the burst is over.
            if (w_beat_final) begin
              if (r_remain != 16'd0) begin
                r_ar_valid <= 1'b1;
                r_state    <= S_ADDRESS;
              end else begin
                r_state <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          if (!r_t_valid || i_dest_t_ready) begin
            r_start_ready <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_start_ready <= 1'b1;
          r_cmd_ready   <= 1'b0;
          r_ar_valid    <= 1'b0;
        end
      endcase
    end
  end

  // Memory must close each burst on exactly the counted final beat.
  a_rlast_match: assert property (@(posedge aclk) disable iff (!aresetn)
    w_r_fire |-> (i_src_r_last == w_beat_final));

  // Read address channel
  assign o_src_ar_valid  = r_ar_valid;
  assign o_src_ar_id     = '0;
  assign o_src_ar_addr   = {r_addr, {ADDR_SHIFT{1'b0}}};
  assign o_src_ar_len    = 8'(w_burst - 16'd1);
  assign o_src_ar_size   = 3'(ADDR_SHIFT);
  assign o_src_ar_burst  = 2'b01;
  assign o_src_ar_lock   = 1'b0;
  assign o_src_ar_cache  = '0;
  assign o_src_ar_prot   = '0;
  assign o_src_ar_qos    = '0;
  assign o_src_ar_region = '0;
  assign o_src_ar_user   = '0;
  assign o_src_r_ready   = w_r_ready;

  // Write side is never used by a read mover.
  assign o_src_aw_valid  = 1'b0;
  assign o_src_aw_id     = '0;
  assign o_src_aw_addr   = '0;
  assign o_src_aw_len    = '0;
  assign o_src_aw_size   = '0;
  assign o_src_aw_burst  = '0;
  assign o_src_aw_lock   = 1'b0;
  assign o_src_aw_cache  = '0;
  assign o_src_aw_prot   = '0;
  assign o_src_aw_qos    = '0;
  assign o_src_aw_region = '0;
  assign o_src_aw_user   = '0;
  assign o_src_w_valid   = 1'b0;
  assign o_src_w_data    = '0;
  assign o_src_w_strb    = '0;
  assign o_src_w_last    = 1'b0;
  assign o_src_w_user    = '0;
  assign o_src_b_ready   = 1'b0;

  // Output stream
  assign o_dest_t_valid = r_t_valid;
  assign o_dest_t_data  = r_t_data;
  assign o_dest_t_last  = r_t_last;
  assign o_dest_t_keep  = '1;
  assign o_dest_t_strb  = '1;

  // Control
  assign o_cmd_t_ready = r_cmd_ready;
  assign o_start_ready = r_start_ready;
  assign o_err         = r_err;

  logic w_unused;
  assign w_unused = ^{i_src_aw_ready, i_src_w_ready, i_src_b_valid, i_src_b_id,
                      i_src_b_resp, i_src_b_user, i_src_r_id, i_src_r_user,
                      i_cmd_t_data[7:0]};

endmodule

// File: tb/tb_nasti_stream_mover.sv
module tb_nasti_stream_mover;
  localparam int CMD_W = 85;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic        aw_valid, aw_lock, w_valid, w_last, b_ready, ar_valid, ar_lock, r_ready;
  logic [0:0]  aw_id, aw_user, w_user, ar_id, ar_user;
  logic [63:0] aw_addr, w_data, ar_addr, t_data;
  logic [7:0]  aw_len, w_strb, ar_len, t_keep, t_strb;
  logic [2:0]  aw_size, aw_prot, ar_size, ar_prot;
  logic [1:0]  aw_burst, ar_burst;
  logic [3:0]  aw_cache, aw_qos, aw_region, ar_cache, ar_qos, ar_region;
  logic        t_valid, t_last, cmd_ready, start_ready, err;

  logic        ar_ready, r_valid, r_last, t_ready, cmd_valid, start_valid;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic [CMD_W-1:0] cmd_data;

  nasti_stream_mover dut (
    .aclk(aclk), .aresetn(aresetn),
    .o_src_aw_valid(aw_valid), .i_src_aw_ready(1'b0), .o_src_aw_id(aw_id),
    .o_src_aw_addr(aw_addr), .o_src_aw_len(aw_len), .o_src_aw_size(aw_size),
    .o_src_aw_burst(aw_burst), .o_src_aw_lock(aw_lock), .o_src_aw_cache(aw_cache),
    .o_src_aw_prot(aw_prot), .o_src_aw_qos(aw_qos), .o_src_aw_region(aw_region),
    .o_src_aw_user(aw_user),
    .o_src_w_valid(w_valid), .i_src_w_ready(1'b0), .o_src_w_data(w_data),
    .o_src_w_strb(w_strb), .o_src_w_last(w_last), .o_src_w_user(w_user),
    .i_src_b_valid(1'b0), .o_src_b_ready(b_ready), .i_src_b_id(1'b0),
    .i_src_b_resp(2'b00), .i_src_b_user(1'b0),
    .o_src_ar_valid(ar_valid), .i_src_ar_ready(ar_ready), .o_src_ar_id(ar_id),
    .o_src_ar_addr(ar_addr), .o_src_ar_len(ar_len), .o_src_ar_size(ar_size),
    .o_src_ar_burst(ar_burst), .o_src_ar_lock(ar_lock), .o_src_ar_cache(ar_cache),
    .o_src_ar_prot(ar_prot), .o_src_ar_qos(ar_qos), .o_src_ar_region(ar_region),
    .o_src_ar_user(ar_user),
    .i_src_r_valid(r_valid), .o_src_r_ready(r_ready), .i_src_r_id(1'b0),
    .i_src_r_data(r_data), .i_src_r_resp(r_resp), .i_src_r_last(r_last),
    .i_src_r_user(1'b0),
    .o_dest_t_valid(t_valid), .i_dest_t_ready(t_ready), .o_dest_t_data(t_data),
    .o_dest_t_keep(t_keep), .o_dest_t_strb(t_strb), .o_dest_t_last(t_last),
    .i_cmd_t_valid(cmd_valid), .o_cmd_t_ready(cmd_ready), .i_cmd_t_data(cmd_data),
    .i_start_valid(start_valid), .o_start_ready(start_ready), .o_err(err)
  );

  typedef struct { logic [63:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [63:0] data; logic last; } beat_t;

  ar_t   exp_ar[$];
  beat_t exp_beats[$];
  int    total = 0, bad = 0;
  int    n_ar = 0, n_out = 0, n_last = 0;
  logic  exp_err = 1'b0;
  logic [63:0] bad_addr = 64'hFFFF_FFFF_FFFF_FFF8;
  bit    sink_mode = 1'b0;   // 0: always ready, 1: toggles each cycle

  // Memory content is a fixed function of the byte address.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {a[31:0] ^ 32'hC0FF_EE00, ~a[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // Compare process: checks DUT outputs against the model every cycle.
  initial begin
    logic p_r_fire, p_r_last, p_stall, rf;
    logic [63:0] p_data;
    ar_t e; beat_t b;
    p_r_fire = 0; p_r_last = 0; p_stall = 0; p_data = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        p_r_fire = 0; p_r_last = 0; p_stall = 0;
        continue;
      end
      chk("err", 64'(err), 64'(exp_err));
      chk("tieoff", 64'({aw_valid, w_valid, b_ready}), 64'(0));
      if (p_r_fire) chk("r_to_t_latency", 64'(t_valid), 64'(1));
      if (p_r_last && exp_ar.size() > 0) chk("rlast_to_ar_latency", 64'(ar_valid), 64'(1));
      if (p_stall) begin
        chk("hold_valid", 64'(t_valid), 64'(1));
        chk("hold_data", t_data, p_data);
      end
      if (t_valid && !t_ready) chk("backpressure_r_ready", 64'(r_ready), 64'(0));
      if (ar_valid && ar_ready) begin
        n_ar++;
        if (exp_ar.size() == 0) chk("ar_unexpected", 64'(1), 64'(0));
        else begin
          e = exp_ar.pop_front();
          chk("ar_addr", ar_addr, e.addr);
          chk("ar_len", 64'(ar_len), 64'(e.len));
          chk("ar_fixed", 64'({ar_id, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
                               ar_qos, ar_region, ar_user}),
              64'({1'b0, 3'd3, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0}));
        end
      end
      if (t_valid && t_ready) begin
        n_out++;
        if (t_last) n_last++;
        if (exp_beats.size() == 0) chk("beat_unexpected", 64'(1), 64'(0));
        else begin
          b = exp_beats.pop_front();
          chk("t_data", t_data, b.data);
          chk("t_last", 64'(t_last), 64'(b.last));
          chk("t_keep_strb", 64'({t_keep, t_strb}), 64'(16'hFFFF));
        end
      end
      rf = r_valid && r_ready;
      if (cmd_valid && cmd_ready) exp_err = 1'b0;
      if (rf && r_resp != 2'b00) exp_err = 1'b1;
      p_r_fire = rf;
      p_r_last = rf && r_last;
      p_stall  = t_valid && !t_ready;
      p_data   = t_data;
    end
  end

  // Memory responder and sink: one burst at a time, r_valid held until taken.
  initial begin
    ar_t pend[$];
    ar_t e;
    logic arf, rf, act;
    logic [63:0] ara, cur;
    logic [7:0] arl;
    int left;
    act = 0; cur = '0; left = 0;
    forever begin
      @(negedge aclk);
      arf = ar_valid && ar_ready; ara = ar_addr; arl = ar_len;
      rf = r_valid && r_ready;
      @(posedge aclk); #1;
      if (!aresetn) begin
        pend.delete(); act = 0; r_valid = 0; r_last = 0; r_resp = 0; t_ready = 1;
      end else begin
        if (rf) begin
          cur += 64'd8; left--;
          if (left == 0) act = 0;
        end
        if (arf) pend.push_back('{ara, arl});
        if (!act && pend.size() > 0) begin
          e = pend.pop_front();
          cur = e.addr; left = int'(e.len) + 1; act = 1;
        end
        r_valid = act;
        r_data  = act ? mem_word(cur) : 64'd0;
        r_last  = act && (left == 1);
        r_resp  = (act && cur == bad_addr) ? 2'b10 : 2'b00;
        t_ready = sink_mode ? !t_ready : 1'b1;
      end
    end
  end

  task automatic push_model(input logic [63:0] baddr, input int len);
    logic [63:0] a; int rem, bl;
    a = baddr; rem = len;
    while (rem > 0) begin
      bl = (rem > 8) ? 8 : rem;
      exp_ar.push_back('{a, 8'(bl - 1)});
      a += 64'(bl * 8); rem -= bl;
    end
    for (int i = 0; i < len; i++)
      exp_beats.push_back('{mem_word(baddr + 64'(i * 8)), (i == len - 1)});
  endtask

  task automatic issue_cmd(input logic [63:0] baddr, input int len, input bit wait_done);
    logic sf, cf, acc, done;
    @(posedge aclk); #1;
    start_valid = 1; cmd_valid = 1;
    cmd_data = {baddr[63:3], 16'(len), 8'hA5};
    acc = 0;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge aclk);
      sf = start_valid && start_ready;
      cf = cmd_valid && cmd_ready;
      @(posedge aclk); #1;
      if (sf) start_valid = 0;
      if (cf) begin cmd_valid = 0; acc = 1; end
    end
    chk("cmd_accepted", 64'(acc), 64'(1));
    start_valid = 0; cmd_valid = 0;
    @(negedge aclk);
    if (len == 0) chk("len0_start_ready_next", 64'(start_ready), 64'(1));
    else          chk("cmd_to_ar_latency", 64'(ar_valid), 64'(1));
    if (wait_done) begin
      done = 0;
      for (int c = 0; c < 2000; c++) begin
        if (exp_ar.size() == 0 && exp_beats.size() == 0 && start_ready) begin
          done = 1; break;
        end
        @(negedge aclk);
      end
      chk("cmd_complete", 64'(done), 64'(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int b_ar, b_out, b_last;
    logic ok;
    aresetn = 0; ar_ready = 1; r_valid = 0; r_last = 0; r_data = '0; r_resp = 0;
    t_ready = 1; cmd_valid = 0; start_valid = 0; cmd_data = '0;
    repeat (2) @(negedge aclk);
    #2;
    chk("rst_outputs", 64'({ar_valid, r_ready, t_valid, t_last, cmd_ready, start_ready, err}),
        64'(7'b0000010));
    aresetn = 1;

    chk("model_mem_word", mem_word(64'h1000), 64'hC0FF_FE00_FFFF_EFFF);

    // len=8, sink always ready
    b_ar = n_ar; b_out = n_out; b_last = n_last;
    push_model(64'h1000, 8);
    chk("model_ar0_addr", exp_ar[0].addr, 64'h1000);
    chk("model_ar0_len", 64'(exp_ar[0].len), 64'd7);
    issue_cmd(64'h1000, 8, 1);
    chk("t8_ars", 64'(n_ar - b_ar), 64'd1);
    chk("t8_beats", 64'(n_out - b_out), 64'd8);
    chk("t8_lasts", 64'(n_last - b_last), 64'd1);
    chk("t8_idle", 64'(start_ready), 64'd1);

    // len=20 splits into 8+8+4
    b_ar = n_ar; b_out = n_out; b_last = n_last;
    push_model(64'h1000, 20);
    chk("model_ar_count", 64'(exp_ar.size()), 64'd3);
    chk("model_ar1", {exp_ar[1].addr[55:0], exp_ar[1].len}, {56'h1040, 8'd7});
    chk("model_ar2", {exp_ar[2].addr[55:0], exp_ar[2].len}, {56'h1080, 8'd3});
    issue_cmd(64'h1000, 20, 1);
    chk("t20_ars", 64'(n_ar - b_ar), 64'd3);
    chk("t20_beats", 64'(n_out - b_out), 64'd20);
    chk("t20_lasts", 64'(n_last - b_last), 64'd1);

    // len=0: nothing moves
    b_ar = n_ar; b_out = n_out;
    issue_cmd(64'h1800, 0, 1);
    repeat (3) @(negedge aclk);
    chk("t0_ars", 64'(n_ar - b_ar), 64'd0);
    chk("t0_beats", 64'(n_out - b_out), 64'd0);

    // toggling sink
    sink_mode = 1;
    b_out = n_out; b_last = n_last;
    push_model(64'h1400, 8);
    issue_cmd(64'h1400, 8, 1);
    chk("tog_beats", 64'(n_out - b_out), 64'd8);
    chk("tog_lasts", 64'(n_last - b_last), 64'd1);
    sink_mode = 0;

    // error response on beat 3 of 4
    bad_addr = 64'h2010;
    b_out = n_out;
    push_model(64'h2000, 4);
    issue_cmd(64'h2000, 4, 1);
    chk("err_beats", 64'(n_out - b_out), 64'd4);
    repeat (2) @(negedge aclk);
    chk("err_sticky", 64'(err), 64'd1);
    bad_addr = 64'hFFFF_FFFF_FFFF_FFF8;
    push_model(64'h2100, 2);
    issue_cmd(64'h2100, 2, 1);
    chk("err_cleared", 64'(err), 64'd0);

    // reset during READ of an 8-beat command
    b_out = n_out;
    push_model(64'h3000, 8);
    issue_cmd(64'h3000, 8, 0);
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      if (n_out - b_out >= 4) begin ok = 1; break; end
      @(negedge aclk);
    end
    chk("rst_reach_beat5", 64'(ok), 64'd1);
    @(negedge aclk); #2;
    aresetn = 0;
    #1;
    chk("midrst_outputs", 64'({ar_valid, r_ready, t_valid, t_last, cmd_ready, start_ready, err}),
        64'(7'b0000010));
    exp_ar.delete(); exp_beats.delete(); exp_err = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk); #2;
    aresetn = 1;
    b_ar = n_ar; b_out = n_out; b_last = n_last;
    push_model(64'h3000, 5);
    issue_cmd(64'h3000, 5, 1);
    chk("post_rst_ars", 64'(n_ar - b_ar), 64'd1);
    chk("post_rst_beats", 64'(n_out - b_out), 64'd5);
    chk("post_rst_lasts", 64'(n_last - b_last), 64'd1);

    repeat (3) @(negedge aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
